cell_empty_ctrl: RTL

- Sequencer for one cell's secondary (empty) position memory during motion update.
- Fill phase: streams updated particles into addresses 1..N, then commits the particle count N to address 0.
- Readback phase: reads the count, then streams the N stored particles out to the next-iteration loader.
- Sits between the motion-update unit and the single-port cell memory; it is the sole master of that memory's address, data, rden and wren.

---
 rtl/cell_empty_ctrl_if.sv | 28 ++
 rtl/cell_empty_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cell_empty_ctrl_if.sv
// Memory-side bus of the empty-cell controller: one single-port RAM with separate
// read and write enables and a registered read port (q valid one cycle after rden).
interface cell_empty_ctrl_if #(
   parameter int DATA_WIDTH = 96,
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;
   logic                  mem_wren;
   logic                  mem_rden;
   logic [DATA_WIDTH-1:0] mem_q;

   modport master (
      output mem_addr,
      output mem_data,
      output mem_wren,
      output mem_rden,
      input  mem_q
   );

   modport slave (
      input  mem_addr,
      input  mem_data,
      input  mem_wren,
      input  mem_rden,
      output mem_q
   );
endinterface

// File: rtl/cell_empty_ctrl.sv
// Sequencer for one cell's secondary position memory: fills particles into
// addresses 1..N, commits N to address 0, and later streams them back out.
module cell_empty_ctrl #(
   parameter int DATA_WIDTH   = 96,
   parameter int PARTICLE_NUM = 220,
   parameter int ADDR_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fill_start,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   input  logic                  commit,
   output logic                  commit_done,
   input  logic                  rd_start,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  rd_done,
   output logic [ADDR_WIDTH-1:0] count,
   output logic                  overflow,
   output logic                  busy,
   cell_empty_ctrl_if.master     mem
);

   // Address 0 holds the count, so only PARTICLE_NUM-1 particles fit.
   localparam logic [ADDR_WIDTH-1:0] CAP = ADDR_WIDTH'(PARTICLE_NUM - 1);

   typedef enum logic [2:0] {IDLE, FILL, COMMIT, RD_CNT, RD_WAIT, STREAM} state_t;

   state_t                state;
   state_t                state_next;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic                  has_room;
   logic                  accept;
   logic                  stream_rd;
   logic [ADDR_WIDTH-1:0] stored_cnt;
   logic [ADDR_WIDTH-1:0] total;

   assign has_room   = (count < CAP);
   assign accept     = (state == FILL) && in_valid && has_room;
   assign stream_rd  = (state == STREAM) && (rd_ptr <= {1'b0, count});
   assign stored_cnt = mem.mem_q[ADDR_WIDTH-1:0];
   assign total      = (stored_cnt > CAP) ? CAP : stored_cnt;
   assign in_ready   = (state == FILL) && has_room;
   assign busy       = (state != IDLE);
   assign out_data   = out_valid ? mem.mem_q : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // The write address during fill is count+1, which keeps a separate write pointer unnecessary.
   always_comb begin
      state_next   = state;
      mem.mem_wren = 1'b0;
      mem.mem_rden = 1'b0;
      mem.mem_addr = '0;
      mem.mem_data = '0;
      case (state)
         IDLE: begin
            if (fill_start) begin
               state_next = FILL;
            end else if (rd_start) begin
               state_next = RD_CNT;
            end
         end
         FILL: begin
            if (accept) begin
               mem.mem_wren = 1'b1;
               mem.mem_addr = count + 1'b1;
               mem.mem_data = in_data;
            end
            if (commit) begin
               state_next = COMMIT;
            end
         end
         COMMIT: begin
            mem.mem_wren = 1'b1;
            mem.mem_data = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, count};
            state_next   = IDLE;
         end
         RD_CNT: begin
            mem.mem_rden = 1'b1;
            state_next   = RD_WAIT;
         end
         RD_WAIT: begin
            state_next = (total == '0) ? IDLE : STREAM;
         end
         STREAM: begin
            if (stream_rd) begin
               mem.mem_rden = 1'b1;
               mem.mem_addr = rd_ptr[ADDR_WIDTH-1:0];
            end
            if (out_last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count       <= '0;
         rd_ptr      <= '0;
         overflow    <= 1'b0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         commit_done <= 1'b0;
         rd_done     <= 1'b0;
      end else begin
         out_valid   <= stream_rd;
         out_last    <= stream_rd && (rd_ptr == {1'b0, count});
         commit_done <= (state == COMMIT);
         rd_done     <= ((state == RD_WAIT) && (total == '0)) ||
                        ((state == STREAM) && out_last);
         if ((state == IDLE) && fill_start) begin
            count    <= '0;
            overflow <= 1'b0;
         end
         if (accept) begin
            count <= count + 1'b1;
         end
         if ((state == FILL) && in_valid && !has_room) begin
            overflow <= 1'b1;
         end
         if (state == RD_WAIT) begin
            count  <= total;
            rd_ptr <= {{ADDR_WIDTH{1'b0}}, 1'b1};
         end
         if (stream_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule
